// File: rtl/lsu_mem_stage_pkg.sv
// Shared constants, state encoding and small decode helpers for the
// load/store memory stage.
package lsu_mem_stage_pkg;

   // RV32I load funct3 encodings
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   // RV32I store funct3 encodings
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_REQ  = 2'b01,
      ST_WAIT = 2'b10
   } lsu_state_e;

   // True when funct3 names a real RV32I load or store.
   function automatic logic op_legal(input logic is_store, input logic [2:0] funct3);
      logic ok;
      if (is_store) begin
         case (funct3)
            F3_SB, F3_SH, F3_SW: ok = 1'b1;
            default:             ok = 1'b0;
         endcase
      end else begin
         case (funct3)
            F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: ok = 1'b1;
            default:                             ok = 1'b0;
         endcase
      end
      return ok;
   endfunction

   // True when the byte offset breaks natural alignment for the access size.
   function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
      logic mis;
      case (funct3[1:0])
         2'b01:   mis = off[0];
         2'b10:   mis = (off != 2'b00);
         default: mis = 1'b0;
      endcase
      return mis;
   endfunction

   // Rounds the byte offset down to the natural alignment of the access size.
   function automatic logic [1:0] natural_off(input logic [2:0] funct3, input logic [1:0] off);
      logic [1:0] res;
      case (funct3[1:0])
         2'b01:   res = {off[1], 1'b0};
         2'b10:   res = 2'b00;
         default: res = off;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/lsu_mem_stage_align.sv
// Byte-lane steering: byte enables and replicated write data on the store
// side, lane extraction plus sign/zero extension on the load side.
module lsu_mem_stage_align
   import lsu_mem_stage_pkg::*;
(
   input  logic [1:0]  st_size,
   input  logic [1:0]  st_off,
   input  logic [31:0] st_data,
   output logic [3:0]  st_be,
   output logic [31:0] st_wdata,
   input  logic [2:0]  ld_funct3,
   input  logic [1:0]  ld_off,
   input  logic [31:0] ld_rdata,
   output logic [31:0] ld_data
);

   logic [31:0] shifted_s;

   // Store path: lane enables shifted by offset, data replicated across lanes.
   always_comb begin
      st_be    = 4'b0000;
      st_wdata = st_data;
      case (st_size)
         2'b00: begin
            st_be    = 4'b0001 << st_off;
            st_wdata = {4{st_data[7:0]}};
         end
         2'b01: begin
            st_be    = 4'b0011 << st_off;
            st_wdata = {2{st_data[15:0]}};
         end
         2'b10: begin
            st_be    = 4'b1111;
            st_wdata = st_data;
         end
         default: begin
            st_be    = 4'b0000;
            st_wdata = st_data;
         end
      endcase
   end

   // Load path: move the addressed lane to bit 0, then extend per funct3.
   always_comb begin
      shifted_s = ld_rdata >> {ld_off, 3'b000};
      case (ld_funct3)
         F3_LB:   ld_data = {{24{shifted_s[7]}}, shifted_s[7:0]};
         F3_LH:   ld_data = {{16{shifted_s[15]}}, shifted_s[15:0]};
         F3_LBU:  ld_data = {24'h000000, shifted_s[7:0]};
         F3_LHU:  ld_data = {16'h0000, shifted_s[15:0]};
         F3_LW:   ld_data = shifted_s;
         default: ld_data = shifted_s;
      endcase
   end

endmodule

// File: rtl/lsu_mem_stage.sv
// Load/store memory stage: one bus transaction per op, stalls execute via
// ex_ready while busy, returns extended load data to writeback.
// Optional build macro LSU_MISALIGN_TRAP_EN: reject misaligned half/word
// accesses with lsu_err instead of forcing natural alignment.
module lsu_mem_stage
   import lsu_mem_stage_pkg::*;
#(
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ex_valid,
   output logic              ex_ready,
   input  logic              ex_is_store,
   input  logic [2:0]        ex_funct3,
   input  logic [DATA_W-1:0] ex_addr,
   input  logic [DATA_W-1:0] ex_wdata,
   input  logic [4:0]        ex_rd,
   output logic              mem_req,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_addr,
   output logic [3:0]        mem_be,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              wb_valid,
   output logic [4:0]        wb_rd,
   output logic [DATA_W-1:0] wb_data,
   output logic              lsu_err,
   output logic              busy
);

   localparam logic        TO_EN_C   = (TIMEOUT_CYCLES != 32'd0);
   localparam logic [31:0] TO_LAST_C = (TIMEOUT_CYCLES == 32'd0) ? 32'd0 : (TIMEOUT_CYCLES - 32'd1);

   lsu_state_e        state_r, state_s;
   logic              accept_s, reject_s, complete_s, abort_s, timeout_s, bad_s;
   logic [1:0]        off_s;
   logic [3:0]        be_s;
   logic [DATA_W-1:0] wdata_s, ld_data_s;
   logic [2:0]        funct3_r;
   logic [1:0]        off_r;
   logic [4:0]        rd_r;
   logic [31:0]       cnt_r;
   logic              ex_ready_r, mem_req_r, mem_we_r, wb_valid_r, lsu_err_r, busy_r;
   logic [DATA_W-1:0] mem_addr_r, mem_wdata_r, wb_data_r;
   logic [3:0]        mem_be_r;
   logic [4:0]        wb_rd_r;

   // Decide whether the presented op is rejected, and which lane offset it uses.
   always_comb begin
`ifdef LSU_MISALIGN_TRAP_EN
      bad_s = !op_legal(ex_is_store, ex_funct3) || is_misaligned(ex_funct3, ex_addr[1:0]);
      off_s = ex_addr[1:0];
`else
      bad_s = !op_legal(ex_is_store, ex_funct3);
      off_s = natural_off(ex_funct3, ex_addr[1:0]);
`endif
   end

   lsu_mem_stage_align u_lsu_align (
      .st_size   (ex_funct3[1:0]),
      .st_off    (off_s),
      .st_data   (ex_wdata),
      .st_be     (be_s),
      .st_wdata  (wdata_s),
      .ld_funct3 (funct3_r),
      .ld_off    (off_r),
      .ld_rdata  (mem_rdata),
      .ld_data   (ld_data_s)
   );

   // Timeout fires on the last permitted cycle in REQ/WAIT.
   always_comb begin
      if (TO_EN_C && (cnt_r == TO_LAST_C)) begin
         timeout_s = 1'b1;
      end else begin
         timeout_s = 1'b0;
      end
   end

   // Next-state and event decode; completion takes priority over timeout.
   always_comb begin
      state_s    = state_r;
      accept_s   = 1'b0;
      reject_s   = 1'b0;
      complete_s = 1'b0;
      abort_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (ex_valid && bad_s) begin
               reject_s = 1'b1;
            end else if (ex_valid) begin
               accept_s = 1'b1;
               state_s  = ST_REQ;
            end else begin
               state_s  = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (mem_gnt && mem_we_r) begin
               state_s = ST_IDLE;
            end else if (mem_gnt && mem_rvalid) begin
               complete_s = 1'b1;
               state_s    = ST_IDLE;
            end else if (timeout_s) begin
               abort_s = 1'b1;
               state_s = ST_IDLE;
            end else if (mem_gnt) begin
               state_s = ST_WAIT;
            end else begin
               state_s = ST_REQ;
            end
         end
         ST_WAIT: begin
            if (mem_rvalid) begin
               complete_s = 1'b1;
               state_s    = ST_IDLE;
            end else if (timeout_s) begin
               abort_s = 1'b1;
               state_s = ST_IDLE;
            end else begin
               state_s = ST_WAIT;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // State, latched op, bus fields, timeout counter and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         funct3_r    <= 3'b000;
         off_r       <= 2'b00;
         rd_r        <= 5'd0;
         cnt_r       <= 32'd0;
         ex_ready_r  <= 1'b1;
         mem_req_r   <= 1'b0;
         mem_we_r    <= 1'b0;
         mem_addr_r  <= '0;
         mem_be_r    <= 4'b0000;
         mem_wdata_r <= '0;
         wb_valid_r  <= 1'b0;
         wb_rd_r     <= 5'd0;
         wb_data_r   <= '0;
         lsu_err_r   <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         state_r    <= state_s;
         ex_ready_r <= (state_s == ST_IDLE);
         mem_req_r  <= (state_s == ST_REQ);
         busy_r     <= (state_s != ST_IDLE);
         lsu_err_r  <= reject_s | abort_s;
         wb_valid_r <= complete_s;
         if (complete_s) begin
            wb_rd_r   <= rd_r;
            wb_data_r <= ld_data_s;
         end else begin
            wb_rd_r   <= wb_rd_r;
            wb_data_r <= wb_data_r;
         end
         if (accept_s) begin
            funct3_r    <= ex_funct3;
            off_r       <= off_s;
            rd_r        <= ex_rd;
            mem_we_r    <= ex_is_store;
            mem_addr_r  <= {ex_addr[DATA_W-1:2], 2'b00};
            mem_be_r    <= be_s;
            mem_wdata_r <= wdata_s;
            cnt_r       <= 32'd0;
         end else if (state_r != ST_IDLE) begin
            cnt_r <= cnt_r + 32'd1;
         end else begin
            cnt_r <= cnt_r;
         end
      end
   end

   assign ex_ready  = ex_ready_r;
   assign mem_req   = mem_req_r;
   assign mem_we    = mem_we_r;
   assign mem_addr  = mem_addr_r;
   assign mem_be    = mem_be_r;
   assign mem_wdata = mem_wdata_r;
   assign wb_valid  = wb_valid_r;
   assign wb_rd     = wb_rd_r;
   assign wb_data   = wb_data_r;
   assign lsu_err   = lsu_err_r;
   assign busy      = busy_r;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Scoreboard bench for lsu_mem_stage: a driver issues ops and bus responses,
// a reference model pushes expected bus/writeback/error events, and a
// negedge monitor pops and compares whenever the DUT presents them.
module tb_lsu_mem_stage;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ex_valid = 1'b0, ex_ready, ex_is_store = 1'b0;
   logic [2:0]  ex_funct3 = 3'b000;
   logic [31:0] ex_addr = 32'd0, ex_wdata = 32'd0;
   logic [4:0]  ex_rd = 5'd0;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = 32'd0;
   logic        wb_valid, lsu_err, busy;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } bus_t;
   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } wb_t;

   bus_t exp_bus[$];
   wb_t  exp_wb[$];
   int   err_pend = 0;
   int   checks = 0;
   int   failures = 0;
   logic prev_wb = 1'b0;

   lsu_mem_stage #(.DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst),
      .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_is_store(ex_is_store),
      .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd(ex_rd),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
      .mem_rdata(mem_rdata), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
      .lsu_err(lsu_err), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic bit m_legal(input bit st, input logic [2:0] f3);
      if (st) return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
      return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
   endfunction

   function automatic int m_size(input logic [2:0] f3);
      if (f3[1:0] == 2'd0) return 1;
      if (f3[1:0] == 2'd1) return 2;
      return 4;
   endfunction

   function automatic logic [31:0] m_ext(input logic [2:0] f3, input logic [31:0] rdata, input int off);
      logic [31:0] v;
      v = rdata >> (8 * off);
      case (f3)
         3'd0: begin v = v % 256;   if (v >= 128)   v = v + 32'hFFFFFF00; end
         3'd1: begin v = v % 65536; if (v >= 32768) v = v + 32'hFFFF0000; end
         3'd4: v = v % 256;
         3'd5: v = v % 65536;
         default: v = v;
      endcase
      return v;
   endfunction

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      bus_t b;
      wb_t  w;
      if (!rst) begin
         if (mem_req && mem_gnt) begin
            chk("bus_expected", (exp_bus.size() > 0) ? 32'd1 : 32'd0, 32'd1);
            if (exp_bus.size() > 0) begin
               b = exp_bus.pop_front();
               chk("bus_we", {31'd0, mem_we}, {31'd0, b.we});
               chk("bus_addr", mem_addr, b.addr);
               chk("bus_be", {28'd0, mem_be}, {28'd0, b.be});
               if (b.we) chk("bus_wdata", mem_wdata, b.wdata);
            end
         end
         if (wb_valid) begin
            chk("wb_pulse_width", {31'd0, prev_wb}, 32'd0);
            chk("wb_expected", (exp_wb.size() > 0) ? 32'd1 : 32'd0, 32'd1);
            if (exp_wb.size() > 0) begin
               w = exp_wb.pop_front();
               chk("wb_rd", {27'd0, wb_rd}, {27'd0, w.rd});
               chk("wb_data", wb_data, w.data);
            end
         end
         if (lsu_err) begin
            chk("err_expected", (err_pend > 0) ? 32'd1 : 32'd0, 32'd1);
            if (err_pend > 0) err_pend--;
         end
         prev_wb = wb_valid;
      end else begin
         prev_wb = 1'b0;
      end
   end

   // ---------------- driver ----------------
   task automatic wait_ready();
      int n = 0;
      while (!ex_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk("ex_ready_wait", {31'd0, ex_ready}, 32'd1);
   endtask

   task automatic do_op(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [4:0] rd,
                        input int g, input int r, input logic [31:0] rdata);
      bit   ok, handshake, complete;
      int   sz, off;
      bus_t b;
      wb_t  w;
      wait_ready();
      ex_valid = 1'b1; ex_is_store = st; ex_funct3 = f3;
      ex_addr = addr; ex_wdata = wd; ex_rd = rd;
      @(posedge clk); #1;
      ex_valid = 1'b0; ex_addr = $urandom; ex_wdata = $urandom;
      ok  = m_legal(st, f3);
      sz  = m_size(f3);
      off = addr % 4;
`ifdef LSU_MISALIGN_TRAP_EN
      if ((addr % sz) != 0) ok = 1'b0;
`endif
      off = (off / sz) * sz;
      if (!ok) begin
         err_pend++;
         chk("reject_no_bus", {30'd0, busy, mem_req}, 32'd0);
         @(posedge clk); #1;
         chk("reject_still_idle", {30'd0, busy, mem_req}, 32'd0);
         return;
      end
      chk("req_state", {29'd0, mem_req, busy, ex_ready}, 32'b110);
      handshake = (g + 1 <= TO);
      complete  = st ? handshake : (g + 1 + r <= TO);
      b.we    = st;
      b.addr  = addr - (addr % 4);
      b.be    = ((1 << sz) - 1) << off;
      b.wdata = (sz == 1) ? (wd % 256) * 32'h01010101 :
                (sz == 2) ? (wd % 65536) * 32'h00010001 : wd;
      if (handshake) exp_bus.push_back(b);
      if (!complete) err_pend++;
      else if (!st) begin
         w.rd = rd; w.data = m_ext(f3, rdata, off);
         exp_wb.push_back(w);
      end
      repeat (g) begin @(posedge clk); #1; end
      mem_gnt = 1'b1;
      if (!st && r == 0) begin mem_rvalid = 1'b1; mem_rdata = rdata; end
      @(posedge clk); #1;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
      if (!st && r > 0) begin
         repeat (r - 1) begin @(posedge clk); #1; end
         mem_rvalid = 1'b1; mem_rdata = rdata;
         @(posedge clk); #1;
         mem_rvalid = 1'b0; mem_rdata = $urandom;
      end
      if (complete) begin
         if (st) chk("store_ready_latency", {31'd0, ex_ready}, 32'd1);
         else    chk("wb_latency", {31'd0, wb_valid}, 32'd1);
      end
      @(posedge clk); #1;
      chk("idle_after_op", {30'd0, busy, mem_req}, 32'd0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      bus_t b;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_ex_ready", {31'd0, ex_ready}, 32'd1);
      chk("rst_ctrl", {27'd0, mem_req, mem_we, wb_valid, lsu_err, busy}, 32'd0);
      chk("rst_addr", mem_addr, 32'd0);
      chk("rst_be_wdata", {28'd0, mem_be} | mem_wdata, 32'd0);
      chk("rst_wb", {27'd0, wb_rd} | wb_data, 32'd0);

      do_op(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 5'd1, 0, 0, 32'd0);
      do_op(1'b0, 3'b000, 32'h0000_2001, 32'd0, 5'd5, 0, 2, 32'h0000_80FF);
      do_op(1'b0, 3'b100, 32'h0000_2001, 32'd0, 5'd6, 0, 2, 32'h0000_80FF);
      do_op(1'b0, 3'b001, 32'h0000_2002, 32'd0, 5'd7, 0, 0, 32'h8001_1234);
      do_op(1'b0, 3'b010, 32'h0000_5000, 32'd0, 5'd3, 6, 1, 32'h1234_5678);
      do_op(1'b0, 3'b010, 32'h0000_3002, 32'd0, 5'd4, 0, 1, 32'hDEAD_BEEF);
      do_op(1'b1, 3'b001, 32'h0000_3003, 32'hCAFE_BABE, 5'd0, 1, 0, 32'd0);
      do_op(1'b0, 3'b100, 32'h0000_6003, 32'd0, 5'd0, 1, 1, 32'h9ABC_DEF0);
      do_op(1'b0, 3'b011, 32'h0000_7000, 32'd0, 5'd2, 0, 0, 32'd0);
      do_op(1'b1, 3'b100, 32'h0000_7000, 32'd1, 5'd2, 0, 0, 32'd0);

      // reset while waiting for read data, then a stale rvalid
      wait_ready();
      ex_valid = 1'b1; ex_is_store = 1'b0; ex_funct3 = 3'b010;
      ex_addr = 32'h0000_4000; ex_rd = 5'd9;
      @(posedge clk); #1;
      ex_valid = 1'b0;
      b.we = 1'b0; b.addr = 32'h0000_4000; b.be = 4'b1111; b.wdata = 32'd0;
      exp_bus.push_back(b);
      mem_gnt = 1'b1;
      @(posedge clk); #1;
      mem_gnt = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("midrst_state", {29'd0, busy, mem_req, wb_valid}, 32'd0);
      chk("midrst_ready", {31'd0, ex_ready}, 32'd1);
      mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("midrst_no_wb", {30'd0, wb_valid, busy}, 32'd0);

      for (int i = 0; i < 150; i++) begin
         do_op($urandom_range(0, 1), 3'($urandom_range(0, 7)), $urandom, $urandom,
               5'($urandom_range(0, 31)), $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
      end

      repeat (4) @(posedge clk);
      #1;
      chk("bus_queue_drained", exp_bus.size(), 32'd0);
      chk("wb_queue_drained", exp_wb.size(), 32'd0);
      chk("err_drained", err_pend, 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
